// File: rtl/multiword_add_seq_pkg.sv
// Shared state encoding and counter sizing for the beat-serial multiword adder.
package multiword_add_seq_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = S_IDLE,
        RUN  = S_RUN,
        DONE = S_DONE
    } state_t;

    // Beat counter width: ceil(log2(n)), never below one bit.
    function automatic int cnt_w(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) w++;
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/param_full_adder.sv
// Parameterized combinational ripple-carry adder slice.
module param_full_adder #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[WIDTH];

endmodule

// File: rtl/multiword_add_seq.sv
// Wide add/subtract built from one WIDTH-bit slice reused over WORDS beats,
// linked by a registered carry; result lands atomically with a done pulse.
module multiword_add_seq
    import multiword_add_seq_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int WORDS = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   op_sub,
    input  logic [WIDTH*WORDS-1:0] a_in,
    input  logic [WIDTH*WORDS-1:0] b_in,
    input  logic                   cin,
    output logic                   ready,
    output logic                   busy,
    output logic                   done,
    output logic [WIDTH*WORDS-1:0] sum,
    output logic                   cout,
    output logic                   ovf
);

    localparam int            CW     = cnt_w(WORDS);
    localparam logic [CW-1:0] K_LAST = CW'(WORDS - 1);

    state_t state, state_nx;

    logic [CW-1:0]                 k;
    logic                          carry;
    logic [WORDS-1:0][WIDTH-1:0]   a_reg;
    logic [WORDS-1:0][WIDTH-1:0]   b_reg;
    logic [WORDS-1:0][WIDTH-1:0]   work_reg;
    logic [WORDS-1:0][WIDTH-1:0]   work_nx;

    logic [WIDTH-1:0] s_sum;
    logic             s_co;
    logic             accept;
    logic             last;

    assign ready  = (state != RUN);
    assign busy   = (state == RUN);
    assign done   = (state == DONE);
    assign accept = ready && start;
    assign last   = (k == K_LAST);

    param_full_adder #(.WIDTH(WIDTH)) u_slice (
        .a    (a_reg[k]),
        .b    (b_reg[k]),
        .cin  (carry),
        .sum  (s_sum),
        .cout (s_co)
    );

    // Final result is the accumulated words with this beat's slice merged in.
    always_comb begin
        work_nx    = work_reg;
        work_nx[k] = s_sum;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (last)  state_nx = DONE;
            DONE:    state_nx = start ? RUN : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k        <= '0;
            carry    <= 1'b0;
            a_reg    <= '0;
            b_reg    <= '0;
            work_reg <= '0;
            sum      <= '0;
            cout     <= 1'b0;
            ovf      <= 1'b0;
        end else if (accept) begin
            // Subtract is a + ~b + 1, so cin is ignored in that mode.
            a_reg <= a_in;
            b_reg <= op_sub ? ~b_in : b_in;
            carry <= op_sub ? 1'b1 : cin;
            k     <= '0;
        end else if (state == RUN) begin
            work_reg[k] <= s_sum;
            carry       <= s_co;
            if (last) begin
                sum  <= work_nx;
                cout <= s_co;
                ovf  <= (a_reg[WORDS-1][WIDTH-1] == b_reg[WORDS-1][WIDTH-1]) &&
                        (s_sum[WIDTH-1] != a_reg[WORDS-1][WIDTH-1]);
            end else begin
                k <= k + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_multiword_add_seq.sv
// Directed bench for the 16-bit (4x4) beat-serial adder: results, latency and control corners.
module tb_multiword_add_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        op_sub;
    logic [15:0] a_in;
    logic [15:0] b_in;
    logic        cin;
    logic        ready;
    logic        busy;
    logic        done;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;

    int checks = 0;
    int errors = 0;

    multiword_add_seq #(.WIDTH(4), .WORDS(4)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op_sub (op_sub),
        .a_in   (a_in),
        .b_in   (b_in),
        .cin    (cin),
        .ready  (ready),
        .busy   (busy),
        .done   (done),
        .sum    (sum),
        .cout   (cout),
        .ovf    (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [15:0] a, input logic [15:0] b,
                         input logic c, input logic s);
        a_in = a; b_in = b; cin = c; op_sub = s; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Counts negedges after the accepting edge until done; optionally pokes start mid-run.
    task automatic wait_done(input bit poke, output int edges, output int nbusy);
        int n;
        n = 0; nbusy = 0;
        while (n < 30) begin
            @(negedge clk);
            n++;
            if (poke && n == 1) begin
                start = 1'b1; a_in = 16'hFFFF; b_in = 16'hFFFF; op_sub = 1'b0;
            end
            if (poke && n == 2) start = 1'b0;
            if (busy) nbusy++;
            if (done) break;
        end
        if (!done) chk("timeout", 32'(n), 32'd5);
        edges = n - 1;
    endtask

    task automatic expect_res(input string tag, input logic [15:0] es,
                              input logic ec, input logic eo);
        chk({tag, ".sum"},  32'(sum),  32'(es));
        chk({tag, ".cout"}, 32'(cout), 32'(ec));
        chk({tag, ".ovf"},  32'(ovf),  32'(eo));
    endtask

    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic c, input logic s, input logic [15:0] es,
                          input logic ec, input logic eo, input bit poke);
        int edges, nbusy;
        @(negedge clk);
        drive(a, b, c, s);
        wait_done(poke, edges, nbusy);
        chk({tag, ".lat"},  32'(edges), 32'd4);
        chk({tag, ".busy"}, 32'(nbusy), 32'd4);
        expect_res(tag, es, ec, eo);
    endtask

    initial begin
        int edges, nbusy;
        rst_n = 1'b1; start = 1'b0; op_sub = 1'b0; a_in = '0; b_in = '0; cin = 1'b0;

        // Asynchronous reset asserted mid-cycle, checked before the next edge.
        #3 rst_n = 1'b0;
        #1;
        chk("rst.ready", 32'(ready), 32'd1);
        chk("rst.busy",  32'(busy),  32'd0);
        chk("rst.done",  32'(done),  32'd0);
        chk("rst.sum",   32'(sum),   32'd0);
        chk("rst.cout",  32'(cout),  32'd0);
        chk("rst.ovf",   32'(ovf),   32'd0);
        @(negedge clk); rst_n = 1'b1;

        run_op("chain", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("pulse.done",  32'(done),  32'd0);
        chk("pulse.ready", 32'(ready), 32'd1);
        chk("hold.sum",    32'(sum),   32'h0100);

        run_op("wrap",   16'hFFFF, 16'h0001, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b0, 1'b0);
        run_op("subovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
        run_op("subbor", 16'h0000, 16'h0001, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0);

        // start pulsed while RUN is ignored; original operands still produce the result.
        run_op("ignore", 16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        chk("ignore.idle", 32'(ready && !busy), 32'd1);

        // Back-to-back: start held in the DONE cycle.
        run_op("b2b1", 16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0, 1'b0);
        drive(16'h1234, 16'h1111, 1'b0, 1'b0);
        wait_done(1'b0, edges, nbusy);
        chk("b2b2.lat", 32'(edges), 32'd4);
        expect_res("b2b2", 16'h2345, 1'b0, 1'b0);

        // Abort during beat 2, then a clean operation.
        @(negedge clk);
        drive(16'hAAAA, 16'h1111, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort.ready", 32'(ready), 32'd1);
        chk("abort.busy",  32'(busy),  32'd0);
        chk("abort.done",  32'(done),  32'd0);
        expect_res("abort", 16'h0000, 1'b0, 1'b0);
        @(negedge clk); rst_n = 1'b1;
        run_op("after", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
